spi_flash_responder: RTL and testbench

Synthesizable SPI flash target that answers the serial-flash bus driven by the SoC's flash controller (`flash_clk`, `flash_csn`, `flash_io0` out, `flash_io1` in). It oversamples the SPI pins in the system clock domain, decodes READ, JEDEC-ID and READ-STATUS commands, and serves read data from a synchronous byte-wide memory port. It is used as an on-board or simulation loopback target for the boot-from-flash path and runs in SPI mode 0, single-bit I/O.

---
 rtl/spi_flash_pkg.sv | 29 ++
 rtl/sync.sv | 34 +++
 rtl/spi_flash_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_pkg
// Purpose  : Shared opcodes and state encoding for the SPI flash responder.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    ID     = 3'd4,
    STATUS = 3'd5,
    IGNORE = 3'd6
  } spi_state_t;

  // States in which the responder owns the io1 pad.
  function automatic logic is_tx_state(input spi_state_t s);
    return (s == DATA) || (s == ID) || (s == STATUS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync.sv
`default_nettype none
// ============================================================================
// Module   : sync
// Purpose  : Multi-flop synchronizer for one asynchronous input bit.
// Ports    : clk      - destination clock
//            reset_n  - asynchronous active-low reset (chain loads RESET_VAL)
//            d        - asynchronous input
//            q        - synchronized output
// Revision : 1.0 - initial release
// ============================================================================
module sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI mode-0 serial flash target. Oversamples the SPI pins in the
//            clk domain, decodes READ (0x03), JEDEC-ID (0x9F) and
//            READ-STATUS (0x05), and serves READ data from a synchronous
//            byte-wide memory port with a one-byte prefetch buffer.
// Ports    : clk, reset_n            - system clock (>= 4x spi_clk), async reset
//            spi_clk/csn/mosi        - SPI pins from the initiator
//            spi_miso, spi_miso_en   - io1 data and pad enable
//            mem_addr, mem_rd        - memory read request (1-cycle strobe)
//            mem_rdata               - read data, valid 1 clk after mem_rd
//            busy                    - synced chip select is active
//            cmd_err                 - 1-cycle pulse on unsupported opcode
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_en,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        cmd_err
);

  logic w_sclk_s, w_csn_s, w_mosi_s;
  logic r_sclk_d, r_csn_d;
  logic w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;

  spi_state_t r_state, w_next_state;

  logic [4:0]  r_bit_cnt;
  logic [22:0] r_shift_in;
  logic [7:0]  r_shift_out, r_buf;
  logic [1:0]  r_id_idx, w_id_next_idx;
  logic        r_need_load, r_rd_inflight;
  logic        r_miso, r_mem_rd, r_cmd_err;
  logic [23:0] r_mem_addr;
  logic [7:0]  w_opcode, w_cur_byte, w_next_byte;
  logic [23:0] w_addr;
  logic        w_enter_addr, w_enter_data, w_enter_id, w_enter_status, w_enter_ignore;

  // chip select idles high, so its chain resets to 1 to avoid a false fall
  sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(spi_clk), .q(w_sclk_s));
  sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(clk), .reset_n(reset_n), .d(spi_csn), .q(w_csn_s));
  sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(w_mosi_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_d <= 1'b0;
      r_csn_d  <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_csn_d  <= w_csn_s;
    end
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_csn_fall  = ~w_csn_s & r_csn_d;
  assign w_csn_rise  = w_csn_s & ~r_csn_d;

  // The bit arriving on this rise completes the opcode / address.
  assign w_opcode = {r_shift_in[6:0], w_mosi_s};
  assign w_addr   = {r_shift_in, w_mosi_s};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a chip-select rise overrides everything
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_csn_fall) w_next_state = CMD;
      CMD: begin
        if (w_sclk_rise && (r_bit_cnt == 5'd7)) begin
          case (w_opcode)
            CMD_READ: w_next_state = ADDR;
            CMD_RDID: w_next_state = ID;
            CMD_RDSR: w_next_state = STATUS;
            default:  w_next_state = IGNORE;
          endcase
        end
      end
      ADDR: if (w_sclk_rise && (r_bit_cnt == 5'd23)) w_next_state = DATA;
      default: ;
    endcase
    if (w_csn_rise) w_next_state = IDLE;
  end

  // Outputs and transition strobes
  always_comb begin
    spi_miso_en    = is_tx_state(r_state) && !w_csn_s;
    busy           = !w_csn_s;
    w_enter_addr   = (r_state == CMD)  && (w_next_state == ADDR);
    w_enter_id     = (r_state == CMD)  && (w_next_state == ID);
    w_enter_status = (r_state == CMD)  && (w_next_state == STATUS);
    w_enter_ignore = (r_state == CMD)  && (w_next_state == IGNORE);
    w_enter_data   = (r_state == ADDR) && (w_next_state == DATA);
  end

  // At the tightest clock ratio the first memory byte can arrive in the same
  // cycle as the first falling edge, so bypass it straight into the shifter.
  assign w_cur_byte = (r_need_load && r_rd_inflight) ? mem_rdata : r_shift_out;

  always_comb begin
    w_id_next_idx = (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
    case (r_state)
      DATA: w_next_byte = r_buf;
      ID: begin
        case (w_id_next_idx)
          2'd0:    w_next_byte = JEDEC_ID[23:16];
          2'd1:    w_next_byte = JEDEC_ID[15:8];
          default: w_next_byte = JEDEC_ID[7:0];
        endcase
      end
      default: w_next_byte = 8'h00;
    endcase
  end

  // Datapath: shifters, prefetch buffer and memory request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt     <= '0;
      r_shift_in    <= '0;
      r_shift_out   <= '0;
      r_buf         <= '0;
      r_id_idx      <= '0;
      r_need_load   <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_miso        <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_mem_rd      <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_rd_inflight <= r_mem_rd;
      if (w_csn_rise) begin
        // partial bytes and any in-flight read result are abandoned
        r_bit_cnt   <= '0;
        r_need_load <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_csn_fall) r_bit_cnt <= '0;
          CMD, ADDR: begin
            if (w_sclk_rise) begin
              r_shift_in <= {r_shift_in[21:0], w_mosi_s};
              r_bit_cnt  <= r_bit_cnt + 5'd1;
            end
          end
          DATA, ID, STATUS: begin
            if ((r_state == DATA) && r_rd_inflight) begin
              if (r_need_load) begin
                // first byte goes straight to the shifter; prefetch the next
                r_shift_out <= mem_rdata;
                r_need_load <= 1'b0;
                r_mem_rd    <= 1'b1;
                r_mem_addr  <= r_mem_addr + 24'd1;
              end else begin
                r_buf <= mem_rdata;
              end
            end
            if (w_sclk_fall) begin
              r_miso <= w_cur_byte[7];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt   <= '0;
                r_shift_out <= w_next_byte;
                r_id_idx    <= w_id_next_idx;
                if (r_state == DATA) begin
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= r_mem_addr + 24'd1;
                end
              end else begin
                r_shift_out <= {w_cur_byte[6:0], 1'b0};
                r_bit_cnt   <= r_bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
        if (w_enter_addr) r_bit_cnt <= '0;
        if (w_enter_id) begin
          r_shift_out <= JEDEC_ID[23:16];
          r_id_idx    <= 2'd0;
          r_bit_cnt   <= '0;
        end
        if (w_enter_status) begin
          r_shift_out <= 8'h00;
          r_bit_cnt   <= '0;
        end
        if (w_enter_data) begin
          r_mem_rd    <= 1'b1;
          r_mem_addr  <= w_addr;
          r_need_load <= 1'b1;
          r_bit_cnt   <= '0;
        end
        if (w_enter_ignore) r_cmd_err <= 1'b1;
      end
    end
  end

  assign spi_miso = r_miso;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. Acts as the SPI
//            initiator and as the synchronous memory; received bytes are
//            compared against a behavioural model of flash contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam logic [23:0] C_JEDEC = 24'hEF4016;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_en, mem_rd, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hp = 4;           // SPI half period in clk cycles
  logic [7:0]  salt = 8'h00;
  bit          in_hdr = 1'b0;

  logic [23:0] rd_q[$];
  logic [7:0]  rx_q[$];
  int          rd_b2b, err_pulses, err_wide, en_in_hdr, en_seen, en_low;
  logic        prev_rd = 1'b0;
  logic        prev_err = 1'b0;

  spi_flash_responder #(.JEDEC_ID(C_JEDEC), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .spi_csn    (spi_csn),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_en(spi_miso_en),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Flash contents: memory[a] = XOR of address bytes with a per-test salt
  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ salt;
  endfunction

  // Memory port: data valid exactly one clk after mem_rd, garbage otherwise
  initial forever begin
    @(posedge clk);
    mem_rdata <= mem_rd ? mem_f(mem_addr) : 8'($urandom);
  end

  // Bus monitor
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (mem_rd) begin
        rd_q.push_back(mem_addr);
        if (prev_rd) rd_b2b++;
      end
      if (cmd_err) begin
        if (prev_err) err_wide++;
        else          err_pulses++;
      end
      if (spi_miso_en) begin
        en_seen++;
        if (in_hdr) en_in_hdr++;
      end
    end
    prev_rd  = mem_rd;
    prev_err = cmd_err;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: MOSI set while SCK low, MISO sampled at the end of high
  task automatic spi_bit(input logic mo, input bit last_hdr, output logic mi);
    spi_mosi = mo;
    wait_clk(hp);
    if (last_hdr) in_hdr = 1'b0;
    spi_clk = 1'b1;
    wait_clk(hp);
    mi = spi_miso;
    spi_clk = 1'b0;
  endtask

  task automatic clear_mon();
    rd_q.delete();
    rx_q.delete();
    rd_b2b = 0; err_pulses = 0; err_wide = 0;
    en_in_hdr = 0; en_seen = 0; en_low = 0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, input int abits);
    logic d;
    spi_csn = 1'b0;
    in_hdr  = 1'b1;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) spi_bit(op[i], (abits == 0) && (i == 0), d);
    for (int i = 0; i < abits; i++) spi_bit(addr[23-i], i == abits - 1, d);
  endtask

  task automatic recv_bytes(input int n);
    logic d;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_bit(1'($urandom), 1'b0, d);
        b[i] = d;
        if (!spi_miso_en) en_low++;
      end
      rx_q.push_back(b);
    end
  endtask

  task automatic cs_end();
    wait_clk(hp);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    in_hdr   = 1'b0;
    wait_clk(8);
  endtask

  // Full transaction plus reference-model comparison
  task automatic run_txn(input logic [7:0] op, input logic [23:0] addr,
                         input int abits, input int n);
    bit         is_read, is_bad, seq_ok;
    logic [7:0] exp_b;
    clear_mon();
    send_hdr(op, addr, abits);
    recv_bytes(n);
    cs_end();
    is_read = (op == 8'h03) && (abits == 24);
    is_bad  = (op != 8'h03) && (op != 8'h9F) && (op != 8'h05);
    if (!is_bad) begin
      for (int k = 0; k < rx_q.size(); k++) begin
        if (op == 8'h03)      exp_b = mem_f(addr + 24'(k));
        else if (op == 8'h9F) exp_b = 8'(C_JEDEC >> (8 * (2 - (k % 3))));
        else                  exp_b = 8'h00;
        check($sformatf("rx_byte_op%0h_%0d", op, k), 32'(rx_q[k]), 32'(exp_b));
      end
      check("miso_en_in_data", 32'(en_low), 32'd0);
    end
    check("miso_en_in_header", 32'(en_in_hdr), 32'd0);
    check("mem_rd_back_to_back", 32'(rd_b2b), 32'd0);
    check("cmd_err_pulses", 32'(err_pulses), 32'(is_bad));
    check("cmd_err_width", 32'(err_wide), 32'd0);
    if (is_read) begin
      check("mem_rd_count_ok", 32'((rd_q.size() >= n) && (rd_q.size() <= n + 2)), 32'd1);
      seq_ok = (rd_q.size() > 0);
      for (int j = 0; j < rd_q.size(); j++)
        if (rd_q[j] !== addr + 24'(j)) seq_ok = 1'b0;
      check("mem_addr_sequence", 32'(seq_ok), 32'd1);
    end else begin
      check("mem_rd_count", 32'(rd_q.size()), 32'd0);
    end
    if (is_bad) check("miso_en_bad_op", 32'(en_seen), 32'd0);
    check("idle_miso_en", 32'(spi_miso_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Async reset in the middle of a READ data phase
  task automatic reset_test();
    logic d;
    salt = 8'h3C;
    clear_mon();
    send_hdr(8'h03, 24'h123456, 24);
    recv_bytes(1);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, d);
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_miso_en", 32'(spi_miso_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({spi_miso, spi_miso_en, mem_addr, mem_rd, busy, cmd_err}), 32'd0);
    @(negedge clk);
    spi_csn  = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(6);
    run_txn(8'h03, 24'h000020, 24, 2);
  endtask

  initial begin
    int          kind;
    logic [23:0] a;
    logic [7:0]  op;

    reset_n = 1'b0;
    wait_clk(3);
    check("reset_outputs",
          32'({spi_miso, spi_miso_en, mem_addr, mem_rd, busy, cmd_err}), 32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    salt = 8'h00;
    hp   = 4;
    run_txn(8'h03, 24'h000010, 24, 4);   // 10 11 12 13
    run_txn(8'h03, 24'hFFFFFE, 24, 3);   // wraps to 000000
    run_txn(8'h9F, 24'h0, 0, 4);         // EF 40 16 EF
    run_txn(8'h05, 24'h0, 0, 3);         // 00 00 00
    run_txn(8'h5A, 24'h0, 0, 1);         // unsupported opcode
    run_txn(8'h03, 24'h000100, 24, 2);
    run_txn(8'h03, 24'hABC123, 12, 0);   // CS abort in address phase
    run_txn(8'h03, 24'h000020, 24, 1);
    hp = 3;
    reset_test();

    for (int t = 0; t < 14; t++) begin
      kind = int'($urandom_range(0, 3));
      hp   = int'($urandom_range(3, 5));
      salt = 8'($urandom);
      case (kind)
        0: begin
          a = 24'($urandom);
          if ($urandom_range(0, 2) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
          run_txn(8'h03, a, 24, int'($urandom_range(1, 4)));
        end
        1: run_txn(8'h9F, 24'h0, 0, int'($urandom_range(1, 5)));
        2: run_txn(8'h05, 24'h0, 0, int'($urandom_range(1, 3)));
        default: begin
          op = 8'($urandom);
          while ((op == 8'h03) || (op == 8'h9F) || (op == 8'h05)) op = 8'($urandom);
          run_txn(op, 24'h0, 0, 1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
